// File: rtl/calc_sequencer.sv
// Two-byte-instruction accumulator sequencer: fetches opcode/operand pairs from a
// 128-entry command memory, executes ALU ops on an 8-bit accumulator, and halts on HALT or fault.
module calc_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] readReg,
    input  logic [7:0] readData,
    output logic [7:0] writeReg,
    output logic [7:0] writeData,
    output logic       regWrite,
    output logic [7:0] acc,
    output logic       carry,
    output logic       zero,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {IDLE, FETCH_OP, FETCH_ARG, EXEC, HALTED} state_t;

    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_XOR   = 8'h06;
    localparam logic [7:0] OP_STORE = 8'h07;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    state_t     state;
    logic [7:0] pc;
    logic [7:0] opcode;
    logic [7:0] operand;
    logic [8:0] alu_res;
    logic       writes_acc;

    // Bit 8 of alu_res is the new carry; ops that leave carry alone pass the old one through.
    always_comb begin
        alu_res    = {carry, acc};
        writes_acc = 1'b1;
        case (opcode)
            OP_LOAD: alu_res = {carry, operand};
            OP_ADD:  alu_res = {1'b0, acc} + {1'b0, operand};
            OP_SUB:  alu_res = {1'b0, acc} - {1'b0, operand};
            OP_AND:  alu_res = {carry, acc & operand};
            OP_OR:   alu_res = {carry, acc | operand};
            OP_XOR:  alu_res = {carry, acc ^ operand};
            default: writes_acc = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= 8'h00;
            opcode    <= 8'h00;
            operand   <= 8'h00;
            readReg   <= 8'h00;
            writeReg  <= 8'h00;
            writeData <= 8'h00;
            regWrite  <= 1'b0;
            acc       <= 8'h00;
            carry     <= 1'b0;
            zero      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            // NOTE: the write port defaults to idle every cycle, so a STORE pulse can never outlive its EXEC cycle.
            regWrite  <= 1'b0;
            writeReg  <= 8'h00;
            writeData <= 8'h00;
            case (state)
                IDLE: begin
                    if (start) begin
                        pc      <= 8'h00;
                        readReg <= 8'h00;
                        busy    <= 1'b1;
                        state   <= FETCH_OP;
                    end
                end
                FETCH_OP: begin
                    readReg <= 8'h00;
                    if (!pc[7] && readData <= OP_STORE) begin
                        opcode  <= readData;
                        pc      <= pc + 8'd1;
                        readReg <= pc + 8'd1;
                        state   <= FETCH_ARG;
                    end else begin
                        // HALT, undefined opcode, or address out of range.
                        state <= HALTED;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= pc[7] || (readData != OP_HALT);
                    end
                end
                FETCH_ARG: begin
                    readReg <= 8'h00;
                    if (pc[7]) begin
                        state <= HALTED;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else begin
                        operand <= readData;
                        pc      <= pc + 8'd1;
                        state   <= EXEC;
                        if (opcode == OP_STORE) begin
                            regWrite  <= 1'b1;
                            writeReg  <= readData;
                            writeData <= acc;
                        end
                    end
                end
                EXEC: begin
                    if (writes_acc) begin
                        acc   <= alu_res[7:0];
                        carry <= alu_res[8];
                        zero  <= (alu_res[7:0] == 8'h00);
                    end
                    readReg <= pc;
                    state   <= FETCH_OP;
                end
                HALTED: begin
                    if (start) begin
                        acc     <= 8'h00;
                        carry   <= 1'b0;
                        zero    <= 1'b0;
                        error   <= 1'b0;
                        done    <= 1'b0;
                        pc      <= 8'h00;
                        readReg <= 8'h00;
                        busy    <= 1'b1;
                        state   <= FETCH_OP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: an instruction-level interpreter predicts every
// post-edge output snapshot of a run; directed programs pin the interpreter with literals.
module tb_calc_sequencer;

    typedef struct packed {
        logic [7:0] rd_addr;
        logic       wr_en;
        logic [7:0] wr_addr;
        logic [7:0] wr_data;
        logic [7:0] acc;
        logic       carry;
        logic       zero;
        logic       busy;
        logic       done;
        logic       error;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] readReg, readData, writeReg, writeData, acc;
    logic       regWrite, carry, zero, busy, done, error;

    logic [7:0] mem [0:255];
    assign readData = mem[readReg];

    always #5 clk = ~clk;

    calc_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .readReg(readReg), .readData(readData),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .acc(acc), .carry(carry), .zero(zero),
        .busy(busy), .done(done), .error(error)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    snap_t exp_q[$];
    snap_t act_log [0:255];
    int    n_log;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic snap_t dut_snap();
        snap_t s;
        s.rd_addr = readReg;  s.wr_en   = regWrite;
        s.wr_addr = writeReg; s.wr_data = writeData;
        s.acc     = acc;      s.carry   = carry;
        s.zero    = zero;     s.busy    = busy;
        s.done    = done;     s.error   = error;
        return s;
    endfunction

    // Interpret the program in mem and list what the outputs must read after each edge,
    // starting with the edge that samples start.
    task automatic build_model();
        int         pc  = 0;
        int         sum;
        logic [7:0] a   = 8'h00;
        logic [7:0] op, arg;
        logic       c = 1'b0, z = 1'b0, err = 1'b0;
        snap_t      s;
        exp_q.delete();
        for (int guard = 0; guard < 200; guard++) begin
            s = '0; s.acc = a; s.carry = c; s.zero = z; s.busy = 1'b1;
            s.rd_addr = 8'(pc);
            exp_q.push_back(s);
            if (pc >= 128) begin err = 1'b1; break; end
            op = mem[pc];
            if (op == 8'hFF) break;
            if (op > 8'h07) begin err = 1'b1; break; end
            s.rd_addr = 8'(pc + 1);
            exp_q.push_back(s);
            if (pc + 1 >= 128) begin err = 1'b1; break; end
            arg = mem[pc + 1];
            s.rd_addr = 8'h00;
            if (op == 8'h07) begin s.wr_en = 1'b1; s.wr_addr = arg; s.wr_data = a; end
            exp_q.push_back(s);
            case (op)
                8'h01: a = arg;
                8'h02: begin sum = a + arg; c = (sum > 255); a = 8'(sum); end
                8'h03: begin c = (arg > a); a = a - arg; end
                8'h04: a = a & arg;
                8'h05: a = a | arg;
                8'h06: a = a ^ arg;
                default: ;
            endcase
            if (op >= 8'h01 && op <= 8'h06) z = (a == 8'h00);
            pc += 2;
        end
        s = '0; s.acc = a; s.carry = c; s.zero = z; s.done = 1'b1; s.error = err;
        repeat (3) exp_q.push_back(s);
    endtask

    // Pulse start, then compare every cycle against the model; start is randomised while busy.
    task automatic run_program(input string tag, input int abort_at);
        build_model();
        n_log = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            act_log[k] = dut_snap();
            n_log = k + 1;
            check($sformatf("%s cycle %0d", tag, k), act_log[k], exp_q[k]);
            if (k == abort_at) begin
                #1 reset = 1'b1;
                start = 1'b0;
                #1 check({tag, " async reset clears outputs"}, dut_snap(), '0);
                return;
            end
            start = exp_q[k].busy ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic load5(input logic [7:0] b0, b1, b2, b3, b4);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3; mem[4] = b4;
    endtask

    function automatic int write_pulses();
        int n = 0;
        for (int i = 0; i < n_log; i++) if (act_log[i].wr_en) n++;
        return n;
    endfunction

    initial begin
        snap_t last;
        int    len;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("outputs in reset", dut_snap(), '0);
        reset = 1'b0;
        @(negedge clk);
        check("idle after reset", dut_snap(), '0);

        // LOAD 5, ADD 3, HALT
        load5(8'h01, 8'h05, 8'h02, 8'h03, 8'hFF);
        run_program("load_add", -1);
        check("load_add acc after edge N+3", act_log[3].acc, 8'h05);
        check("load_add acc after edge N+6", act_log[6].acc, 8'h08);
        check("load_add done not yet at N+6", act_log[6].done, 1'b0);
        check("load_add done at N+8", act_log[8].done, 1'b1);
        last = act_log[n_log - 1];
        check("load_add carry/zero/error", {last.carry, last.zero, last.error}, 3'b000);

        load5(8'h01, 8'hF0, 8'h02, 8'h20, 8'hFF);
        run_program("add_carry", -1);
        last = act_log[n_log - 1];
        check("add_carry acc/carry", {last.acc, last.carry}, {8'h10, 1'b1});

        load5(8'h01, 8'h03, 8'h03, 8'h05, 8'hFF);
        run_program("sub_borrow", -1);
        last = act_log[n_log - 1];
        check("sub_borrow acc/carry", {last.acc, last.carry}, {8'hFE, 1'b1});

        load5(8'h01, 8'h07, 8'h03, 8'h07, 8'hFF);
        run_program("sub_zero", -1);
        last = act_log[n_log - 1];
        check("sub_zero acc/carry/zero", {last.acc, last.carry, last.zero}, {8'h00, 1'b0, 1'b1});

        load5(8'h01, 8'hAA, 8'h07, 8'h40, 8'hFF);
        run_program("store", -1);
        check("store pulse count", write_pulses(), 1);
        check("store port during EXEC", {act_log[5].wr_en, act_log[5].wr_addr, act_log[5].wr_data},
              {1'b1, 8'h40, 8'hAA});
        check("store done afterwards", act_log[n_log - 1].done, 1'b1);

        load5(8'h09, 8'h11, 8'h01, 8'h22, 8'hFF);
        run_program("bad_opcode", -1);
        last = act_log[1];
        check("bad_opcode halts after one fetch", {last.error, last.done, last.busy, last.acc},
              {1'b1, 1'b1, 1'b0, 8'h00});
        check("bad_opcode no write", write_pulses(), 0);

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[126] = 8'h01;
        mem[127] = 8'h3C;
        run_program("addr_bound", -1);
        last = act_log[n_log - 1];
        check("addr_bound error/done/acc", {last.error, last.done, last.acc}, {1'b1, 1'b1, 8'h3C});
        check("addr_bound faulting fetch address", act_log[192].rd_addr, 8'h80);

        // Reset lands mid-cycle while the STORE is on the write port.
        load5(8'h01, 8'hAA, 8'h07, 8'h40, 8'hFF);
        run_program("store_abort", 5);
        @(posedge clk);
        #1 check("held reset outputs", dut_snap(), '0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("idle after abort %0d", i), dut_snap(), '0);
        end
        run_program("store_rerun", -1);
        check("store_rerun pulse count", write_pulses(), 1);
        check("store_rerun port", {act_log[5].wr_en, act_log[5].wr_addr, act_log[5].wr_data},
              {1'b1, 8'h40, 8'hAA});

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++)
                mem[2*i] = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            if ($urandom_range(0, 7) != 0) mem[2*len] = 8'hFF;
            run_program($sformatf("random%0d", t), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
